// File: rtl/bcd_counter_n.sv
// Synchronous N-digit BCD event counter: sigin synchroniser, up/down, load, wrap pulse, sticky ovf.
// Define BCD_SATURATE_EN to saturate at 9..9 / 0..0 instead of wrapping.
module bcd_counter_n #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_sigin,
    input  logic                  i_cnt_clean,
    input  logic                  i_cnt_en,
    input  logic                  i_up_dn,
    input  logic                  i_load,
    input  logic [4*DIGITS-1:0]   i_load_val,
    output logic [4*DIGITS-1:0]   o_cnt,
    output logic                  o_wrap,
    output logic                  o_ovf
);

    localparam int unsigned W = 4 * DIGITS;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [W-1:0]           r_cnt;
    logic                   r_wrap;
    logic                   r_ovf;

    logic                   w_ev;
    logic [W-1:0]           w_cnt_step;
    logic                   w_carry;
    logic [3:0]             w_digit;
    logic [W-1:0]           w_load_san;
    logic [3:0]             w_nib;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sigin};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_ev = r_sync[SYNC_STAGES-1] & ~r_prev;

    // Carry/borrow chain across all digits; w_carry ends as the top-digit carry/borrow out.
    always_comb begin
        w_cnt_step = r_cnt;
        w_carry    = 1'b1;
        w_digit    = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            w_digit = r_cnt[4*i +: 4];
            if (w_carry) begin
                if (i_up_dn) begin
                    if (w_digit == 4'd9) begin
                        w_cnt_step[4*i +: 4] = 4'd0;
                    end else begin
                        w_cnt_step[4*i +: 4] = w_digit + 4'd1;
                        w_carry              = 1'b0;
                    end
                end else begin
                    if (w_digit == 4'd0) begin
                        w_cnt_step[4*i +: 4] = 4'd9;
                    end else begin
                        w_cnt_step[4*i +: 4] = w_digit - 4'd1;
                        w_carry              = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        w_load_san = '0;
        w_nib      = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            w_nib                = i_load_val[4*i +: 4];
            w_load_san[4*i +: 4] = (w_nib > 4'd9) ? 4'd0 : w_nib;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (!i_cnt_clean) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (i_load) begin
            r_cnt  <= w_load_san;
            r_wrap <= 1'b0;
        end else if (w_ev && i_cnt_en) begin
`ifdef BCD_SATURATE_EN
            r_wrap <= 1'b0;
            if (w_carry) begin
                r_ovf <= 1'b1;
            end else begin
                r_cnt <= w_cnt_step;
            end
`else
            r_cnt  <= w_cnt_step;
            r_wrap <= w_carry;
            if (w_carry) begin
                r_ovf <= 1'b1;
            end
`endif
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_wrap = r_wrap;
    assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench for bcd_counter_n (DIGITS=4, SYNC_STAGES=2) with an expected-value queue.
module tb_bcd_counter_n;

`ifdef BCD_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sigin = 1'b0;
    logic        cnt_clean = 1'b1;
    logic        cnt_en = 1'b1;
    logic        up_dn = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] cnt;
    logic        wrap;
    logic        ovf;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        string       tag;
        logic [15:0] cnt;
        logic        wrap;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    bcd_counter_n #(
        .DIGITS      (4),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_sigin     (sigin),
        .i_cnt_clean (cnt_clean),
        .i_cnt_en    (cnt_en),
        .i_up_dn     (up_dn),
        .i_load      (load),
        .i_load_val  (load_val),
        .o_cnt       (cnt),
        .o_wrap      (wrap),
        .o_ovf       (ovf)
    );

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'((v) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input logic [15:0] c, input logic w, input logic o);
        exp_t e;
        e.tag  = tag;
        e.cnt  = c;
        e.wrap = w;
        e.ovf  = o;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL sb_empty: observed 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        check({e.tag, "_cnt"}, 32'(cnt), 32'(e.cnt));
        check({e.tag, "_wrap"}, 32'(wrap), 32'(e.wrap));
        check({e.tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
    endtask

    // One sigin pulse, 4 clk high / 4 clk low; the count must land on the 3rd edge.
    task automatic ev_pulse(input string tag, input logic [15:0] prev, input logic [15:0] e_cnt,
                            input logic e_wrap, input logic e_ovf);
        @(negedge clk);
        sigin = 1'b1;
        push(tag, e_cnt, e_wrap, e_ovf);
        repeat (2) @(negedge clk);
        check({tag, "_lat"}, 32'(cnt), 32'(prev));
        @(negedge clk);
        pop_check();
        @(negedge clk);
        check({tag, "_wrap_end"}, 32'(wrap), 32'(0));
        sigin = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_load(input string tag, input logic [15:0] v, input logic [15:0] e_cnt,
                           input logic e_ovf);
        @(negedge clk);
        load     = 1'b1;
        load_val = v;
        push(tag, e_cnt, 1'b0, e_ovf);
        @(negedge clk);
        load = 1'b0;
        pop_check();
    endtask

    // Event coinciding with a control: 0 = load, 1 = cnt_clean low, 2 = cnt_en low.
    task automatic ev_with(input string tag, input int kind, input logic [15:0] v,
                           input logic [15:0] e_cnt, input logic e_ovf);
        @(negedge clk);
        sigin = 1'b1;
        repeat (2) @(negedge clk);
        case (kind)
            0: begin load = 1'b1; load_val = v; end
            1: cnt_clean = 1'b0;
            default: cnt_en = 1'b0;
        endcase
        push(tag, e_cnt, 1'b0, e_ovf);
        @(negedge clk);
        load      = 1'b0;
        cnt_clean = 1'b1;
        cnt_en    = 1'b1;
        pop_check();
        @(negedge clk);
        sigin = 1'b0;
        repeat (4) @(negedge clk);
        check({tag, "_hold"}, 32'(cnt), 32'(e_cnt));
    endtask

    initial begin
        int m;

        #1;
        check("rst_cnt", 32'(cnt), 32'(0));
        check("rst_wrap", 32'(wrap), 32'(0));
        check("rst_ovf", 32'(ovf), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        m = 0;
        for (int i = 0; i < 1234; i++) begin
            ev_pulse("up1234", to_bcd(m), to_bcd(m + 1), 1'b0, 1'b0);
            m = m + 1;
        end
        check("final_1234", 32'(cnt), 32'(16'h1234));

        do_load("ld9998", 16'h9998, 16'h9998, 1'b0);
        ev_pulse("up9999", 16'h9998, 16'h9999, 1'b0, 1'b0);
        ev_pulse("upwrap", 16'h9999, SAT ? 16'h9999 : 16'h0000, !SAT, 1'b1);

        do_load("ld0001", 16'h0001, 16'h0001, 1'b1);
        @(negedge clk);
        up_dn = 1'b0;
        repeat (3) @(negedge clk);
        check("updn_nochange", 32'(cnt), 32'(16'h0001));
        ev_pulse("dn0000", 16'h0001, 16'h0000, 1'b0, 1'b1);
        ev_pulse("dnwrap", 16'h0000, SAT ? 16'h0000 : 16'h9999, !SAT, 1'b1);
        do_load("ldA5F3", 16'hA5F3, 16'h0503, 1'b1);

        // Async reset mid-activity, checked between clock edges.
        @(negedge clk);
        sigin = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cnt", 32'(cnt), 32'(0));
        check("arst_wrap", 32'(wrap), 32'(0));
        check("arst_ovf", 32'(ovf), 32'(0));
        sigin = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("arst_hold", 32'(cnt), 32'(0));

        up_dn = 1'b1;
        do_load("ld9999", 16'h9999, 16'h9999, 1'b0);
        ev_pulse("upwrap2", 16'h9999, SAT ? 16'h9999 : 16'h0000, !SAT, 1'b1);
        ev_with("ev_load", 0, 16'h0042, 16'h0042, 1'b1);
        ev_with("ev_clean", 1, 16'h0000, 16'h0000, 1'b0);
        do_load("ld0007", 16'h0007, 16'h0007, 1'b0);
        ev_with("ev_noen", 2, 16'h0000, 16'h0007, 1'b0);

        do_load("ld0050", 16'h0050, 16'h0050, 1'b0);
        m = 50;
        for (int i = 0; i < 3; i++) begin
            ev_pulse("mix_up", to_bcd(m), to_bcd(m + 1), 1'b0, 1'b0);
            m = m + 1;
        end
        @(negedge clk);
        up_dn = 1'b0;
        repeat (3) @(negedge clk);
        check("mix_toggle", 32'(cnt), 32'(16'h0053));
        for (int i = 0; i < 5; i++) begin
            ev_pulse("mix_dn", to_bcd(m), to_bcd(m - 1), 1'b0, 1'b0);
            m = m - 1;
        end
        check("mix_0048", 32'(cnt), 32'(16'h0048));

        // Sub-cycle glitches: one straddling an edge, one between edges.
        up_dn = 1'b1;
        @(negedge clk);
        #4 sigin = 1'b1;
        @(posedge clk);
        #1 sigin = 1'b0;
        #2 sigin = 1'b1;
        #2 sigin = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++;
        assert (cnt === 16'h0048 || cnt === 16'h0049) else begin
            n_fail++;
            $error("FAIL glitch: observed %h expected 0048 or 0049", cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
